// File: rtl/priority_selector.sv
// One-hot priority selector (highest index wins) built as a binary tree of
// 2-input cells, with combinational outputs plus 1-cycle registered copies.
module priority_selector #(
  parameter int NUM_BITS = 16,
  localparam int IDX_BITS = $clog2(NUM_BITS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] req,
  input  logic                en,
  output logic [NUM_BITS-1:0] gnt,
  output logic                req_up,
  output logic [IDX_BITS-1:0] gnt_idx,
  output logic                gnt_vld,
  output logic [NUM_BITS-1:0] gnt_q,
  output logic                req_up_q,
  output logic [IDX_BITS-1:0] gnt_idx_q,
  output logic                gnt_vld_q
);

  logic [NUM_BITS-1:0] gnt_d;
  logic                req_up_d;
  logic [IDX_BITS-1:0] gnt_idx_d;
  logic                gnt_vld_d;

  // Level 0 holds the leaves, level IDX_BITS the root; node j at level l has
  // children 2j (lower half) and 2j+1 (upper half) at level l-1.
  for (genvar l = 0; l <= IDX_BITS; l++) begin : g_lvl
    localparam int W = NUM_BITS >> l;
    logic [W-1:0] lvl_up;
    logic [W-1:0] lvl_en;

    if (l == 0) begin : g_leaf
      assign lvl_up = req;
    end else begin : g_node
      for (genvar j = 0; j < W; j++) begin : g_cell
        assign lvl_up[j] = g_lvl[l-1].lvl_up[2*j+1] | g_lvl[l-1].lvl_up[2*j];
      end
    end

    // Enable flows root-to-leaf; a lower child is masked by its upper sibling.
    if (l == IDX_BITS) begin : g_root
      assign lvl_en = en;
    end else begin : g_child
      for (genvar j = 0; j < W; j++) begin : g_en
        if (j % 2 == 1) begin : g_upper
          assign lvl_en[j] = g_lvl[l+1].lvl_en[j/2];
        end else begin : g_lower
          assign lvl_en[j] = g_lvl[l+1].lvl_en[j/2] & ~lvl_up[j+1];
        end
      end
    end
  end

  assign gnt_d     = g_lvl[0].lvl_en & req;
  assign req_up_d  = g_lvl[IDX_BITS].lvl_up[0];
  assign gnt_vld_d = en & req_up_d;

  // gnt_d is zero or one-hot, so OR-ing the indices of set bits encodes it.
  always_comb begin
    gnt_idx_d = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (gnt_d[i]) gnt_idx_d = gnt_idx_d | IDX_BITS'(i);
    end
  end

  assign gnt     = gnt_d;
  assign req_up  = req_up_d;
  assign gnt_idx = gnt_idx_d;
  assign gnt_vld = gnt_vld_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_q     <= '0;
      req_up_q  <= 1'b0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      req_up_q  <= req_up_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

endmodule

// File: tb/tb_priority_selector.sv
// Bench for priority_selector: directed vectors, reset behaviour, random
// 16-bit sweep and exhaustive 4-bit build, against a highest-set-bit model.
module tb_priority_selector;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [15:0] req;
  logic        en;
  logic [15:0] gnt, gnt_q;
  logic        req_up, req_up_q, gnt_vld, gnt_vld_q;
  logic [3:0]  gnt_idx, gnt_idx_q;

  logic [3:0]  req4;
  logic        en4;
  logic [3:0]  gnt4, gnt4_q;
  logic        req_up4, req_up4_q, gnt_vld4, gnt_vld4_q;
  logic [1:0]  gnt_idx4, gnt_idx4_q;

  int n_cmp = 0;
  int n_err = 0;

  priority_selector #(.NUM_BITS(16)) dut16 (
    .clock(clock), .reset(reset), .req(req), .en(en),
    .gnt(gnt), .req_up(req_up), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld),
    .gnt_q(gnt_q), .req_up_q(req_up_q), .gnt_idx_q(gnt_idx_q), .gnt_vld_q(gnt_vld_q)
  );

  priority_selector #(.NUM_BITS(4)) dut4 (
    .clock(clock), .reset(reset), .req(req4), .en(en4),
    .gnt(gnt4), .req_up(req_up4), .gnt_idx(gnt_idx4), .gnt_vld(gnt_vld4),
    .gnt_q(gnt4_q), .req_up_q(req_up4_q), .gnt_idx_q(gnt_idx4_q), .gnt_vld_q(gnt_vld4_q)
  );

  // Reference: position of the highest set bit among the low w bits, or -1.
  function automatic int hi_bit(input logic [15:0] r, input int w);
    int h = -1;
    for (int i = 0; i < w; i++) if (r[i]) h = i;
    return h;
  endfunction

  task automatic test_reset();
    reset = 1'b0; req = 16'h0; en = 1'b0; req4 = 4'h0; en4 = 1'b0;
    repeat (2) @(posedge clock);
    req = 16'hffff; en = 1'b1; req4 = 4'hf; en4 = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if ({gnt_q, req_up_q, gnt_idx_q, gnt_vld_q} !== 22'h0) begin
      n_err++;
      $display("FAIL reset16_q: got gnt_q=%h up=%b idx=%0d vld=%b, want all 0",
               gnt_q, req_up_q, gnt_idx_q, gnt_vld_q);
    end
    n_cmp++;
    if ({gnt4_q, req_up4_q, gnt_idx4_q, gnt_vld4_q} !== 8'h0) begin
      n_err++;
      $display("FAIL reset4_q: got gnt_q=%h up=%b idx=%0d vld=%b, want all 0",
               gnt4_q, req_up4_q, gnt_idx4_q, gnt_vld4_q);
    end
    n_cmp++;
    if (gnt !== 16'h8000) begin
      n_err++;
      $display("FAIL reset_comb_gnt: got %h want 8000", gnt);
    end
  endtask

  task automatic test_priority();
    logic [15:0] req_t [5] = '{16'h0123, 16'h0001, 16'h0008, 16'hf080, 16'h0400};
    logic [15:0] gnt_t [5] = '{16'h0100, 16'h0001, 16'h0008, 16'h8000, 16'h0400};
    logic [3:0]  idx_t [5] = '{4'd8, 4'd0, 4'd3, 4'd15, 4'd10};
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req = req_t[k]; #1;
      n_cmp++;
      if ({gnt, gnt_idx, gnt_vld, req_up} !== {gnt_t[k], idx_t[k], 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL priority[%0d] req=%h: got gnt=%h idx=%0d vld=%b up=%b, want gnt=%h idx=%0d vld=1 up=1",
                 k, req, gnt, gnt_idx, gnt_vld, req_up, gnt_t[k], idx_t[k]);
      end
    end
  endtask

  task automatic test_disable();
    en = 1'b0; req = 16'hf080; #1;
    n_cmp++;
    if ({gnt, gnt_idx, gnt_vld, req_up} !== {16'h0, 4'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL disable: got gnt=%h idx=%0d vld=%b up=%b, want 0000/0/0/1",
               gnt, gnt_idx, gnt_vld, req_up);
    end
    en = 1'b1; req = 16'h0000; #1;
    n_cmp++;
    if ({gnt, gnt_idx, gnt_vld, req_up} !== {16'h0, 4'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL no_req: got gnt=%h idx=%0d vld=%b up=%b, want 0000/0/0/0",
               gnt, gnt_idx, gnt_vld, req_up);
    end
  endtask

  task automatic test_registered();
    @(negedge clock);
    reset = 1'b1; en = 1'b1; req = 16'h0123; #1;
    n_cmp++;
    if (gnt_q !== 16'h0) begin
      n_err++;
      $display("FAIL reg_before_edge: got gnt_q=%h want 0000", gnt_q);
    end
    @(posedge clock); #1;
    n_cmp++;
    if ({gnt_q, req_up_q, gnt_idx_q, gnt_vld_q} !== {16'h0100, 1'b1, 4'd8, 1'b1}) begin
      n_err++;
      $display("FAIL reg_capture: got gnt_q=%h up=%b idx=%0d vld=%b, want 0100/1/8/1",
               gnt_q, req_up_q, gnt_idx_q, gnt_vld_q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    req = 16'h8000; en = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (gnt_q !== 16'h8000) begin
      n_err++;
      $display("FAIL async_pre: got gnt_q=%h want 8000", gnt_q);
    end
    #2 reset = 1'b0; #1;
    n_cmp++;
    if ({gnt_q, req_up_q, gnt_idx_q, gnt_vld_q} !== 22'h0) begin
      n_err++;
      $display("FAIL async_clear: got gnt_q=%h up=%b idx=%0d vld=%b, want all 0",
               gnt_q, req_up_q, gnt_idx_q, gnt_vld_q);
    end
    n_cmp++;
    if (gnt !== 16'h8000) begin
      n_err++;
      $display("FAIL async_comb: got gnt=%h want 8000", gnt);
    end
    @(posedge clock); #1;
    n_cmp++;
    if ({gnt_q, req_up_q, gnt_idx_q, gnt_vld_q} !== 22'h0) begin
      n_err++;
      $display("FAIL async_hold: got gnt_q=%h up=%b idx=%0d vld=%b, want all 0",
               gnt_q, req_up_q, gnt_idx_q, gnt_vld_q);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_random16();
    logic [15:0] eg;
    logic [3:0]  ei;
    logic        ev, eu;
    int          h;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      req = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) req = 16'h0;
      en = ($urandom_range(0, 3) != 0);
      h  = hi_bit(req, 16);
      eu = (h >= 0);
      ev = en && eu;
      eg = ev ? (16'h1 << h) : 16'h0;
      ei = ev ? 4'(h) : 4'd0;
      #1;
      n_cmp++;
      if ({gnt, req_up, gnt_idx, gnt_vld} !== {eg, eu, ei, ev} || $countones(gnt) > 1) begin
        n_err++;
        $display("FAIL rand16 req=%h en=%b: got gnt=%h up=%b idx=%0d vld=%b, want gnt=%h up=%b idx=%0d vld=%b",
                 req, en, gnt, req_up, gnt_idx, gnt_vld, eg, eu, ei, ev);
      end
      @(posedge clock); #1;
      n_cmp++;
      if ({gnt_q, req_up_q, gnt_idx_q, gnt_vld_q} !== {eg, eu, ei, ev}) begin
        n_err++;
        $display("FAIL rand16_q req=%h en=%b: got gnt_q=%h up=%b idx=%0d vld=%b, want gnt=%h up=%b idx=%0d vld=%b",
                 req, en, gnt_q, req_up_q, gnt_idx_q, gnt_vld_q, eg, eu, ei, ev);
      end
    end
  endtask

  task automatic test_exhaustive4();
    logic [3:0] eg;
    logic [1:0] ei;
    logic       ev, eu;
    int         h;
    for (int e = 0; e < 2; e++) begin
      for (int r = 0; r < 16; r++) begin
        @(negedge clock);
        req4 = 4'(r);
        en4  = (e == 1);
        h  = hi_bit({12'h0, req4}, 4);
        eu = (h >= 0);
        ev = en4 && eu;
        eg = ev ? (4'h1 << h) : 4'h0;
        ei = ev ? 2'(h) : 2'd0;
        #1;
        n_cmp++;
        if ({gnt4, req_up4, gnt_idx4, gnt_vld4} !== {eg, eu, ei, ev}) begin
          n_err++;
          $display("FAIL exh4 req=%h en=%b: got gnt=%h up=%b idx=%0d vld=%b, want gnt=%h up=%b idx=%0d vld=%b",
                   req4, en4, gnt4, req_up4, gnt_idx4, gnt_vld4, eg, eu, ei, ev);
        end
        @(posedge clock); #1;
        n_cmp++;
        if ({gnt4_q, req_up4_q, gnt_idx4_q, gnt_vld4_q} !== {eg, eu, ei, ev}) begin
          n_err++;
          $display("FAIL exh4_q req=%h en=%b: got gnt_q=%h up=%b idx=%0d vld=%b, want gnt=%h up=%b idx=%0d vld=%b",
                   req4, en4, gnt4_q, req_up4_q, gnt_idx4_q, gnt_vld4_q, eg, eu, ei, ev);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_disable();
    test_registered();
    test_async_reset();
    test_random16();
    test_exhaustive4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/priority_selector.md
Name: priority_selector

Overview:
- Parameterised one-hot priority selector, highest index wins.
- Takes an N-bit request vector and an enable, and grants exactly one request.
- Also reports whether any request is present.
- Grant/request-present outputs are combinational for same-cycle use by allocators (RS/ROB/free-list slot pickers). Registered copies and an encoded grant index are provided for pipelined consumers.

Parameters:
- NUM_BITS, 16, width of request/grant vectors; must be a power of two, >= 2.
- IDX_BITS, $clog2(NUM_BITS), width of the encoded grant index (derived; not overridden).

Ports:
- clock, input, 1, rising-edge clock for registered outputs.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- req, input, NUM_BITS, request vector; bit i = requester i.
- en, input, 1, grant enable.
- gnt, output, NUM_BITS, combinational one-hot grant.
- req_up, output, 1, combinational OR of all req bits.
- gnt_idx, output, IDX_BITS, combinational binary index of the granted bit.
- gnt_vld, output, 1, combinational: en & req_up.
- gnt_q, output, NUM_BITS, gnt registered.
- req_up_q, output, 1, req_up registered.
- gnt_idx_q, output, IDX_BITS, gnt_idx registered.
- gnt_vld_q, output, 1, gnt_vld registered.

Behaviour:
- Priority: the highest-index set bit of req wins. gnt has only that bit set when en=1.
- en=0: gnt = all zeros, gnt_idx = 0, gnt_vld = 0. req_up is still |req (independent of en).
- req = 0: gnt = 0, req_up = 0, gnt_idx = 0, gnt_vld = 0, regardless of en.
- gnt is always zero or one-hot. It never has more than one bit set.
- gnt_idx equals the position of the set bit of gnt. It is 0 when gnt = 0; use gnt_vld to disambiguate from a grant of bit 0.
- Combinational outputs:
  - Zero-latency: respond in the same delta/cycle as req/en changes.
  - No dependence on clock or reset.
- Structure:
  - Implement as a recursive/generate binary tree of 2-input selector cells.
  - Each cell forwards req_up = left|right and gives priority to its upper half.
  - Cell enable flows down the tree; an upper-half request masks the lower half.
  - Depth is log2(NUM_BITS).
- Registered outputs:
  - Sample the combinational values on every rising clock edge; no stall/enable.
  - Latency: 1 cycle.
- Reset:
  - When reset=0, gnt_q, req_up_q, gnt_idx_q and gnt_vld_q go to 0 immediately (asynchronous) and hold 0 while reset is low.
  - First capture occurs on the first rising edge after reset returns to 1.
  - Combinational outputs are unaffected by reset.
- Reset asserted mid-operation: registered outputs clear without waiting for an edge. Combinational path continues normally.
- No internal state other than the output registers. No X-propagation tolerance is required: X on req may produce X outputs.

Test Plan:
- en=1, req=16'h0123 -> gnt=16'h0100, req_up=1, gnt_idx=8, gnt_vld=1. Then req=16'h0001 -> gnt=16'h0001, gnt_idx=0, gnt_vld=1.
- en=1, req=16'h0008 -> gnt=16'h0008, gnt_idx=3. Then req=16'hf080 -> gnt=16'h8000, gnt_idx=15. Then req=16'h0400 -> gnt=16'h0400, gnt_idx=10.
- en=0, req=16'hf080 -> gnt=16'h0000, gnt_idx=0, gnt_vld=0, req_up=1. Then en=1, req=16'h0000 -> gnt=0, req_up=0, gnt_vld=0.
- Registered path: reset=0 for 2 cycles -> all *_q = 0. Release reset, drive en=1, req=16'h0123 before edge N -> after edge N: gnt_q=16'h0100, req_up_q=1, gnt_idx_q=8, gnt_vld_q=1.
- Async reset: with gnt_q=16'h8000, drop reset to 0 between edges -> all *_q = 0 before the next rising edge. Combinational gnt is still 16'h8000.
- Exhaustive/random sweep with NUM_BITS=16, and a build with NUM_BITS=4 (all 16 req values x en). For each input, check:
  - gnt is one-hot or zero.
  - gnt bit equals the highest set bit of req when en=1.
  - req_up == |req.
  - gnt_idx matches gnt.
